// File: rtl/clint_tick_master_pkg.sv
// Shared encodings for the CLINT tick master: FSM states,
// CLINT offsets and request/response bit positions.
`define REQ_W (1 + ADDR_W + DATA_W + DATA_W / 8)
`define RESP_W (DATA_W + 1)

package clint_tick_master_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_HI0,
    RD_LO,
    RD_HI1,
    WR_LO_MAX,
    WR_HI,
    WR_LO,
    ARMED,
    DISARM
`ifdef CLINT_TICK_MSIP_EN
    , WR_MSIP
`endif
  } state_t;

  localparam logic [31:0] OFF_MSIP = 32'h0000_0000;
  localparam logic [31:0] OFF_MTIMECMP = 32'h0000_4000;
  localparam logic [31:0] OFF_MTIME = 32'h0000_BFF8;

  // req = {valid, address, wdata, wstrb}; resp = {rdata, ready}
  localparam int REQ_WSTRB = 0;
  localparam int RESP_READY = 0;
  localparam int RESP_RDATA = 1;

  function automatic int req_wdata_lsb(int dw);
    return dw / 8;
  endfunction

  function automatic int req_addr_lsb(int dw);
    return dw + dw / 8;
  endfunction

  function automatic int req_valid_bit(int aw, int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/clint_tick_bus_if.sv
// Single-outstanding valid/ready initiator; the FSM holds cmd
// while it waits and sees a one-cycle done with read data.
module clint_tick_bus_if
  import clint_tick_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [`REQ_W-1:0] req,
  input  logic [`RESP_W-1:0] resp
);

  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;

  assign ready = resp[RESP_READY];
  assign rdata = resp[RESP_RDATA +: DATA_W];
  assign done = valid & ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
    end else if (valid) begin
      if (ready) valid <= 1'b0;
    end else if (cmd) begin
      valid <= 1'b1;
      addr <= cmd_addr;
      wdata <= cmd_we ? cmd_wdata : '0;
      wstrb <= cmd_we ? '1 : '0;
    end
  end

  always_comb begin
    req = '0;
    req[req_valid_bit(ADDR_W, DATA_W)] = valid;
    req[req_addr_lsb(DATA_W) +: ADDR_W] = addr;
    req[req_wdata_lsb(DATA_W) +: DATA_W] = wdata;
    req[REQ_WSTRB +: DATA_W/8] = wstrb;
  end

endmodule

// File: rtl/clint_tick_master.sv
// Programs mtimecmp for a periodic timer tick over a simple bus.
// CLINT_TICK_MSIP_EN adds sw_irq and an msip write state.
module clint_tick_master
  import clint_tick_master_pkg::*;
#(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32,
  parameter logic [ADDR_W-1:0] CLINT_BASE = 32'h0200_0000,
  parameter int              HART_ID = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [`REQ_W-1:0]  req,
  input  logic [`RESP_W-1:0] resp,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        period,
  input  logic               mtip,
`ifdef CLINT_TICK_MSIP_EN
  input  logic               sw_irq,
`endif
  output logic               busy,
  output logic               tick,
  output logic [15:0]        tick_cnt
);

  localparam logic [ADDR_W-1:0] A_CMP_LO =
    CLINT_BASE + ADDR_W'(OFF_MTIMECMP) + ADDR_W'(8 * HART_ID);
  localparam logic [ADDR_W-1:0] A_CMP_HI = A_CMP_LO + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_MT_LO = CLINT_BASE + ADDR_W'(OFF_MTIME);
  localparam logic [ADDR_W-1:0] A_MT_HI = A_MT_LO + ADDR_W'(4);
`ifdef CLINT_TICK_MSIP_EN
  localparam logic [ADDR_W-1:0] A_MSIP =
    CLINT_BASE + ADDR_W'(OFF_MSIP) + ADDR_W'(4 * HART_ID);
`endif

  state_t              state_q, state_d;
  logic                cmd, cmd_we, done, fire;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata, rdata;
  logic [DATA_W-1:0]   hi0, lo;
  logic [31:0]         period_q;
  logic [63:0]         next;
  logic                stop_q, stop_pend, sw_pend;

  assign stop_pend = stop | stop_q;

`ifdef CLINT_TICK_MSIP_EN
  logic sw_q, ret_armed;
  assign sw_pend = sw_irq | sw_q;
`else
  assign sw_pend = 1'b0;
`endif

  clint_tick_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .done     (done),
    .rdata    (rdata),
    .req      (req),
    .resp     (resp)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RD_HI0;
`ifdef CLINT_TICK_MSIP_EN
        else if (sw_pend) state_d = WR_MSIP;
`endif
      end
      RD_HI0: if (done) state_d = stop_pend ? DISARM : RD_LO;
      RD_LO: if (done) state_d = stop_pend ? DISARM : RD_HI1;
      RD_HI1: begin
        // hi moved between reads: lo may belong to either epoch
        if (done) begin
          if (stop_pend) state_d = DISARM;
          else if (rdata != hi0) state_d = RD_LO;
          else state_d = WR_LO_MAX;
        end
      end
      WR_LO_MAX: if (done) state_d = stop_pend ? DISARM : WR_HI;
      WR_HI: if (done) state_d = stop_pend ? DISARM : WR_LO;
      WR_LO: if (done) state_d = stop_pend ? DISARM : ARMED;
      ARMED: begin
        if (stop_pend) state_d = DISARM;
        else if (sw_pend) state_d = state_q;
        else if (mtip) state_d = WR_LO_MAX;
`ifdef CLINT_TICK_MSIP_EN
        if (!stop_pend && sw_pend) state_d = WR_MSIP;
`endif
      end
      DISARM: if (done) state_d = IDLE;
`ifdef CLINT_TICK_MSIP_EN
      WR_MSIP: begin
        if (done) begin
          if (!ret_armed) state_d = IDLE;
          else state_d = stop_pend ? DISARM : ARMED;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    busy = (state_q != IDLE);
    fire = (state_q == ARMED) & mtip & ~stop_pend & ~sw_pend;
    unique case (state_q)
      RD_HI0, RD_HI1: begin
        cmd = 1'b1;
        cmd_addr = A_MT_HI;
      end
      RD_LO: begin
        cmd = 1'b1;
        cmd_addr = A_MT_LO;
      end
      WR_LO_MAX: begin
        cmd = 1'b1;
        cmd_we = 1'b1;
        cmd_addr = A_CMP_LO;
        cmd_wdata = '1;
      end
      WR_HI: begin
        cmd = 1'b1;
        cmd_we = 1'b1;
        cmd_addr = A_CMP_HI;
        cmd_wdata = DATA_W'(next[63:32]);
      end
      WR_LO: begin
        cmd = 1'b1;
        cmd_we = 1'b1;
        cmd_addr = A_CMP_LO;
        cmd_wdata = DATA_W'(next[31:0]);
      end
      DISARM: begin
        cmd = 1'b1;
        cmd_we = 1'b1;
        cmd_addr = A_CMP_HI;
        cmd_wdata = '1;
      end
`ifdef CLINT_TICK_MSIP_EN
      WR_MSIP: begin
        cmd = 1'b1;
        cmd_we = 1'b1;
        cmd_addr = A_MSIP;
        cmd_wdata = DATA_W'(1);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      hi0 <= '0;
      lo <= '0;
      next <= '0;
      stop_q <= 1'b0;
      tick <= 1'b0;
      tick_cnt <= '0;
    end else begin
      stop_q <= (state_d == IDLE) ? 1'b0 : stop_pend;
      tick <= fire;
      if (state_q == IDLE && start) period_q <= period;
      if (done && state_q == RD_HI0) hi0 <= rdata;
      if (done && state_q == RD_LO) lo <= rdata;
      if (done && state_q == RD_HI1) begin
        if (rdata != hi0) hi0 <= rdata;
        else next <= {hi0, lo} + {32'd0, period_q};
      end
      if (fire) begin
        next <= next + {32'd0, period_q};
        tick_cnt <= tick_cnt + 16'd1;
      end
    end
  end

`ifdef CLINT_TICK_MSIP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_q <= 1'b0;
      ret_armed <= 1'b0;
    end else begin
      sw_q <= (state_q == WR_MSIP && done) ? sw_irq : sw_pend;
      if (state_d == WR_MSIP && state_q != WR_MSIP)
        ret_armed <= (state_q == ARMED);
    end
  end
`endif

endmodule
